// File: rtl/sumprod_pkg.sv
// Shared definitions for the sum-of-operands multiplier: FSM state encoding
// and the iteration-count and width helpers used by the datapath.
package sumprod_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREADD = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of K-bit digits needed to cover a (w+1)-bit pre-added operand.
  function automatic int calc_n(input int w, input int k);
    return (w + k) / k;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prod_width(input int w);
    return 2 * (w + 1);
  endfunction

endpackage

// File: rtl/sumprod_digit_mac.sv
// One digit step of the multiplier: acc_next = acc + (a * digit) << (idx * K).
// Purely combinational; the caller owns all state.
module sumprod_digit_mac
  import sumprod_pkg::*;
#(
  parameter int W  = 255,
  parameter int K  = 16,
  parameter int IW = 4
) (
  input  logic [W:0]               a,
  input  logic [K-1:0]             digit,
  input  logic [IW-1:0]            idx,
  input  logic [prod_width(W)-1:0] acc,
  output logic [prod_width(W)-1:0] acc_next
);

  localparam int PW  = prod_width(W);
  localparam int PRW = W + 1 + K;

  logic [PRW-1:0] prod_s;
  logic [PW-1:0]  shifted_s;

  // Partial product of A with one digit, aligned to the digit position.
  always_comb begin
    prod_s    = PRW'(a) * PRW'(digit);
    shifted_s = PW'(prod_s) << (K * int'(idx));
    acc_next  = acc + shifted_s;
  end

endmodule

// File: rtl/sumprod_mult.sv
// Iterative (x1[+y1]) * (x2[+y2]) multiplier: one K-bit digit of B per cycle,
// fixed latency of N+2 cycles from acceptance to out_valid.
module sumprod_mult
  import sumprod_pkg::*;
#(
  parameter int W = 255,
  parameter int K = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             x1,
  input  logic [W-1:0]             y1,
  input  logic [W-1:0]             x2,
  input  logic [W-1:0]             y2,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_width(W)-1:0] result
);

  localparam int N  = calc_n(W, K);
  localparam int NK = N * K;
  localparam int PW = prod_width(W);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  logic [1:0]    state_r;
  logic [W-1:0]  x1_r, y1_r, x2_r, y2_r;
  logic [1:0]    mode_r;
  logic [W:0]    a_r;
  logic [NK-1:0] b_r;
  logic [PW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [W:0]    a_sum_s;
  logic [W:0]    b_sum_s;
  logic [PW-1:0] mac_acc_s;

  // Optional pre-add, one bit wider than the operands so no carry is lost.
  always_comb begin
    a_sum_s = mode_r[0] ? ({1'b0, x1_r} + {1'b0, y1_r}) : {1'b0, x1_r};
    b_sum_s = mode_r[1] ? ({1'b0, x2_r} + {1'b0, y2_r}) : {1'b0, x2_r};
  end

  sumprod_digit_mac #(
    .W  (W),
    .K  (K),
    .IW (CW)
  ) u_mac (
    .a        (a_r),
    .digit    (b_r[K-1:0]),
    .idx      (cnt_r),
    .acc      (acc_r),
    .acc_next (mac_acc_s)
  );

  // Control FSM with operand capture, digit iteration and result hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      x1_r        <= '0;
      y1_r        <= '0;
      x2_r        <= '0;
      y2_r        <= '0;
      mode_r      <= 2'b00;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x1_r       <= x1;
            y1_r       <= y1;
            x2_r       <= x2;
            y2_r       <= y2;
            mode_r     <= mode;
            in_ready_r <= 1'b0;
            state_r    <= ST_PREADD;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_PREADD: begin
          a_r     <= a_sum_s;
          b_r     <= NK'(b_sum_s);
          acc_r   <= '0;
          cnt_r   <= '0;
          state_r <= ST_MUL;
        end
        ST_MUL: begin
          // B is consumed LSB digit first; zero digits still take their cycle.
          acc_r <= mac_acc_s;
          b_r   <= b_r >> K;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_DIGIT) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r     <= ST_MUL;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = acc_r;

endmodule

// File: tb/tb_sumprod_mult.sv
// Scoreboard bench: two W=7 instances (K=4, K=3) share directed stimulus,
// a default-size instance takes randomised back-to-back requests.
module tb_sumprod_mult;

  typedef struct {
    logic [511:0] val;
    int           acc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]   s_x1, s_y1, s_x2, s_y2;
  logic [1:0]   s_mode;
  logic         s_in_valid, s_out_ready;
  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0]  a_result, b_result;

  logic [254:0] c_x1, c_y1, c_x2, c_y2;
  logic [1:0]   c_mode;
  logic         c_in_valid, c_out_ready, c_in_ready, c_out_valid;
  logic [511:0] c_result;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   pa = 1'b0, pb = 1'b0, pc = 1'b0;
  exp_t qa[$], qb[$], qc[$];
  int   lat_exp[3] = '{4, 5, 18};

  sumprod_mult #(.W(7), .K(4)) u_a (
    .clk(clk), .reset(reset), .x1(s_x1), .y1(s_y1), .x2(s_x2), .y2(s_y2),
    .mode(s_mode), .in_valid(s_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(s_out_ready), .result(a_result)
  );

  sumprod_mult #(.W(7), .K(3)) u_b (
    .clk(clk), .reset(reset), .x1(s_x1), .y1(s_y1), .x2(s_x2), .y2(s_y2),
    .mode(s_mode), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(s_out_ready), .result(b_result)
  );

  sumprod_mult u_c (
    .clk(clk), .reset(reset), .x1(c_x1), .y1(c_y1), .x2(c_x2), .y2(c_y2),
    .mode(c_mode), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_result)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] z16(input logic [15:0] v);
    return {496'd0, v};
  endfunction

  function automatic logic [511:0] z1(input logic v);
    return {511'd0, v};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  task automatic mon_pop(input int id, input logic [511:0] act);
    exp_t e;
    bit   have = 1'b0;
    case (id)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_out_valid dut%0d: result %0h with no request pending", id, act);
    end else begin
      chk($sformatf("result_dut%0d", id), act, e.val);
      chk($sformatf("latency_dut%0d", id), 512'(cyc - e.acc), 512'(lat_exp[id]));
    end
  endtask

  // Monitor: pops one expectation on each rising out_valid of each DUT.
  always @(negedge clk) begin
    if (!reset && a_out_valid && !pa) mon_pop(0, z16(a_result));
    if (!reset && b_out_valid && !pb) mon_pop(1, z16(b_result));
    if (!reset && c_out_valid && !pc) mon_pop(2, c_result);
    pa <= !reset && a_out_valid;
    pb <= !reset && b_out_valid;
    pc <= !reset && c_out_valid;
  end

  task automatic issue_ab(input int x1, input int y1, input int x2, input int y2,
                          input int m, input logic [511:0] ev);
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_in_ready && b_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("accept_ab");
    end else begin
      s_x1 = 7'(x1); s_y1 = 7'(y1); s_x2 = 7'(x2); s_y2 = 7'(y2);
      s_mode = 2'(m);
      s_in_valid = 1'b1;
      qa.push_back('{ev, cyc});
      qb.push_back('{ev, cyc});
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      s_x1 = 7'($urandom); s_y1 = 7'($urandom); s_x2 = 7'($urandom); s_y2 = 7'($urandom);
      s_mode = 2'($urandom);
    end
  endtask

  task automatic drain_ab();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && a_in_ready && b_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain_ab");
  endtask

  task automatic issue_c(input logic [254:0] x1, input logic [254:0] y1,
                         input logic [254:0] x2, input logic [254:0] y2, input logic [1:0] m);
    logic [511:0] ea, eb;
    bit           ok = 1'b0;
    ea = m[0] ? ({257'd0, x1} + {257'd0, y1}) : {257'd0, x1};
    eb = m[1] ? ({257'd0, x2} + {257'd0, y2}) : {257'd0, x2};
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (c_in_ready) begin
        ok = 1'b1;
        break;
      end
      c_out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      timeout("accept_c");
    end else begin
      c_x1 = x1; c_y1 = y1; c_x2 = x2; c_y2 = y2; c_mode = m;
      c_in_valid = 1'b1;
      qc.push_back('{ea * eb, cyc});
      @(posedge clk);
      #1;
      c_in_valid = 1'b0;
      c_x1 = ~x1; c_y1 = ~y1; c_x2 = 255'(y2 ^ x1); c_y2 = 255'(x2 ^ y1);
      c_mode = ~m;
    end
  endtask

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
    return t[254:0];
  endfunction

  int tx1[7] = '{3, 127, 100, 10, 10, 1, 127};
  int ty1[7] = '{5, 127, 77, 20, 20, 0, 0};
  int tx2[7] = '{2, 127, 50, 7, 7, 64, 0};
  int ty2[7] = '{4, 127, 99, 9, 9, 0, 0};
  int tm[7]  = '{3, 3, 0, 1, 2, 3, 3};
  int te[7]  = '{48, 64516, 5000, 210, 160, 64, 0};

  initial begin
    logic [254:0] ones;
    bit           ok;
    ones = '1;
    s_x1 = 7'd0; s_y1 = 7'd0; s_x2 = 7'd0; s_y2 = 7'd0; s_mode = 2'd0;
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    c_x1 = '0; c_y1 = '0; c_x2 = '0; c_y2 = '0; c_mode = 2'd0;
    c_in_valid = 1'b0; c_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid_a", z1(a_out_valid), 512'd0);
    chk("rst_out_valid_b", z1(b_out_valid), 512'd0);
    chk("rst_out_valid_c", z1(c_out_valid), 512'd0);
    chk("rst_result_a", z16(a_result), 512'd0);
    chk("rst_result_b", z16(b_result), 512'd0);
    chk("rst_result_c", c_result, 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rel_in_ready_a", z1(a_in_ready), 512'd1);
    chk("rel_in_ready_b", z1(b_in_ready), 512'd1);
    chk("rel_in_ready_c", z1(c_in_ready), 512'd1);

    // Directed vectors; the first is accepted on the first edge after release.
    for (int i = 0; i < 7; i++) issue_ab(tx1[i], ty1[i], tx2[i], ty2[i], tm[i], 512'(te[i]));
    drain_ab();

    // Result held in DONE while out_ready is low; in_valid pulses ignored.
    s_out_ready = 1'b0;
    issue_ab(9, 3, 5, 6, 3, 512'd132);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("reach_done_b");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_out_valid_a", z1(a_out_valid), 512'd1);
      chk("hold_result_a", z16(a_result), 512'd132);
      chk("hold_result_b", z16(b_result), 512'd132);
      chk("hold_in_ready_a", z1(a_in_ready), 512'd0);
      chk("hold_in_ready_b", z1(b_in_ready), 512'd0);
      s_in_valid = k[0];
      s_x1 = 7'($urandom); s_x2 = 7'($urandom); s_mode = 2'($urandom);
    end
    @(negedge clk);
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    s_x1 = 7'd20; s_y1 = 7'd1; s_x2 = 7'd30; s_y2 = 7'd0; s_mode = 2'd1;
    @(negedge clk);
    chk("after_done_in_ready_a", z1(a_in_ready), 512'd1);
    chk("after_done_in_ready_b", z1(b_in_ready), 512'd1);
    qa.push_back('{512'd630, cyc});
    qb.push_back('{512'd630, cyc});
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    drain_ab();

    // Reset during MUL aborts the request; the next one computes normally.
    issue_ab(5, 0, 6, 0, 3, 512'd30);
    @(posedge clk);
    #1;
    reset = 1'b1;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("abort_out_valid_a", z1(a_out_valid), 512'd0);
    chk("abort_result_a", z16(a_result), 512'd0);
    chk("abort_result_b", z16(b_result), 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_a", z1(a_in_ready), 512'd1);
    chk("abort_in_ready_b", z1(b_in_ready), 512'd1);
    repeat (10) @(negedge clk);
    chk("abort_no_valid_b", z1(b_out_valid), 512'd0);
    issue_ab(12, 3, 10, 1, 3, 512'd165);
    drain_ab();

    // Default-size instance: all-ones first, then random back-to-back traffic.
    issue_c(ones, ones, ones, ones, 2'd3);
    for (int i = 1; i < 200; i++) issue_c(rnd255(), rnd255(), rnd255(), rnd255(), 2'($urandom));
    c_out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (qc.size() == 0 && c_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain_c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
